// File: rtl/uart_pkt_tx.sv
// uart_pkt_tx: 8N1 UART packet serialiser (SYNC, op, 4 data bytes); define UART_PKT_CHECKSUM_EN to append an XOR checksum byte
module uart_pkt_tx #(
  parameter int         CLKS_PER_BIT = 430,
  parameter int         GAP_CLKS     = 0,
  parameter logic [7:0] SYNC_BYTE    = 8'd100
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [7:0]  pkt_op,
  input  logic [31:0] pkt_data,
  output logic        tx,
  output logic        busy
);
  localparam int MAX_CLKS = CLKS_PER_BIT > GAP_CLKS ? CLKS_PER_BIT : GAP_CLKS;
  localparam int CW = $clog2(MAX_CLKS + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CLKS - 1);
`ifdef UART_PKT_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd6;
`else
  localparam logic [2:0] LAST_BYTE = 3'd5;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d, byte_q, byte_d;
  logic [7:0] op_q, op_d, cur_byte;
  logic [31:0] data_q, data_d;
  logic tx_q, tx_d, ready_q, ready_d;
  logic bit_done, gap_done;
  assign bit_done = cnt_q == BIT_END;
  assign gap_done = cnt_q == GAP_END;
  // next-state: walk start/data/stop of each byte, optional gap between bytes
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    byte_d = byte_q;
    op_d = op_q;
    data_d = data_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pkt_valid) begin
          state_d = START;
          byte_d = '0;
          bit_d = '0;
          op_d = pkt_op;
          data_d = pkt_data;
        end
      end
      START: if (bit_done) begin
        state_d = DATA;
        cnt_d = '0;
        bit_d = '0;
      end
      DATA: if (bit_done) begin
        cnt_d = '0;
        bit_d = bit_q == 3'd7 ? bit_q : bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_done) begin
        cnt_d = '0;
        if (byte_q == LAST_BYTE) state_d = IDLE;
        else begin
          byte_d = byte_q + 1'b1;
          state_d = GAP_CLKS > 0 ? GAP : START;
        end
      end
      GAP: if (gap_done) begin
        cnt_d = '0;
        state_d = START;
      end
      default: state_d = IDLE;
    endcase
  end
  // byte selected by the next byte index, from the next captured packet
  always_comb begin
    cur_byte = byte_d == 3'd0 ? SYNC_BYTE :
               byte_d == 3'd1 ? op_d :
               byte_d == 3'd2 ? data_d[7:0] :
               byte_d == 3'd3 ? data_d[15:8] :
               byte_d == 3'd4 ? data_d[23:16] :
`ifdef UART_PKT_CHECKSUM_EN
               byte_d == 3'd5 ? data_d[31:24] :
               op_d ^ data_d[7:0] ^ data_d[15:8] ^ data_d[23:16] ^ data_d[31:24];
`else
               data_d[31:24];
`endif
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? cur_byte[bit_d] : 1'b1;
    ready_d = state_d == IDLE;
  end
  // state, counters, captured packet and registered outputs
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      op_q <= '0;
      data_q <= '0;
      tx_q <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      op_q <= op_d;
      data_q <= data_d;
      tx_q <= tx_d;
      ready_q <= ready_d;
    end
  end
  assign tx = tx_q;
  assign pkt_ready = ready_q;
  assign busy = ~ready_q;
endmodule

// File: tb/tb_uart_pkt_tx.sv
// tb_uart_pkt_tx: directed/randomised bench for uart_pkt_tx against a bit-level waveform model
module tb_uart_pkt_tx;
`ifdef UART_PKT_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nRst;
  logic [2:0] vld, rdy, txl, bsy;
  logic [7:0] op;
  logic [31:0] data;
  int tests = 0;
  int fails = 0;
  bit cap_q[$];
  bit exp_q[$];
  logic [7:0] pkt_b[$];

  uart_pkt_tx #(.CLKS_PER_BIT(430), .GAP_CLKS(0)) u_a (.clk(clk), .nRst(nRst), .pkt_valid(vld[0]), .pkt_ready(rdy[0]),
    .pkt_op(op), .pkt_data(data), .tx(txl[0]), .busy(bsy[0]));
  uart_pkt_tx #(.CLKS_PER_BIT(8), .GAP_CLKS(0)) u_b (.clk(clk), .nRst(nRst), .pkt_valid(vld[1]), .pkt_ready(rdy[1]),
    .pkt_op(op), .pkt_data(data), .tx(txl[1]), .busy(bsy[1]));
  uart_pkt_tx #(.CLKS_PER_BIT(43), .GAP_CLKS(860)) u_c (.clk(clk), .nRst(nRst), .pkt_valid(vld[2]), .pkt_ready(rdy[2]),
    .pkt_op(op), .pkt_data(data), .tx(txl[2]), .busy(bsy[2]));

  function automatic int cpb_of(input int k);
    return k == 0 ? 430 : k == 1 ? 8 : 43;
  endfunction
  function automatic int gap_of(input int k);
    return k == 2 ? 860 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // expected tx line, one entry per clock, from first start-bit cycle to last stop-bit cycle
  task automatic build(input int k, input logic [7:0] o, input logic [31:0] d);
    pkt_b.delete();
    exp_q.delete();
    pkt_b.push_back(8'd100);
    pkt_b.push_back(o);
    for (int i = 0; i < 4; i++) pkt_b.push_back(d[8*i +: 8]);
    if (NB == 7) pkt_b.push_back(o ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]);
    for (int i = 0; i < NB; i++) begin
      repeat (cpb_of(k)) exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (cpb_of(k)) exp_q.push_back(pkt_b[i][b]);
      repeat (cpb_of(k)) exp_q.push_back(1'b1);
      if (i < NB - 1) repeat (gap_of(k)) exp_q.push_back(1'b1);
    end
  endtask

  // called at the sample point of the first cycle after accept; n = cycles from accept to pkt_ready
  task automatic capture(input int k, output int n);
    cap_q.delete();
    n = 1;
    cap_q.push_back(txl[k]);
    while (!rdy[k] && n < 40000) begin
      step();
      n++;
      if (!rdy[k]) cap_q.push_back(txl[k]);
    end
  endtask

  task automatic verify(input string tag, input int k, input logic [7:0] o, input logic [31:0] d, output int n);
    int cpb, bad, i;
    logic [7:0] v;
    logic [7:0] dec[$];
    cpb = cpb_of(k);
    check({tag, " tx low after accept"}, 64'(txl[k]), 0);
    check({tag, " busy after accept"}, 64'(bsy[k]), 1);
    build(k, o, d);
    capture(k, n);
    check({tag, " accept-to-ready"}, n, exp_q.size() + 1);
    check({tag, " length"}, cap_q.size(), exp_q.size());
    bad = 0;
    for (int j = 0; j < cap_q.size() && j < exp_q.size(); j++) if (cap_q[j] != exp_q[j]) bad++;
    check({tag, " waveform bad cycles"}, bad, 0);
    i = 0;
    while (i + 10 * cpb <= cap_q.size()) begin
      if (cap_q[i] == 1'b0) begin
        for (int b = 0; b < 8; b++) v[b] = cap_q[i + cpb * (b + 1) + cpb / 2];
        dec.push_back(v);
        i += 10 * cpb;
      end else i++;
    end
    check({tag, " byte count"}, dec.size(), NB);
    for (int j = 0; j < NB; j++)
      check($sformatf("%s byte%0d", tag, j), j < dec.size() ? 64'(dec[j]) : 'x, 64'(pkt_b[j]));
    check({tag, " ready at end"}, 64'(rdy[k]), 1);
    check({tag, " busy at end"}, 64'(bsy[k]), 0);
  endtask

  initial begin
    int n, at;
    logic [7:0] o;
    logic [31:0] d;
    nRst = 1'b0;
    vld = '0;
    op = '0;
    data = '0;
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset tx%0d", k), 64'(txl[k]), 1);
      check($sformatf("reset ready%0d", k), 64'(rdy[k]), 1);
      check($sformatf("reset busy%0d", k), 64'(bsy[k]), 0);
    end
    nRst = 1'b1;
    step();
    // reference packet at 430 clocks per bit; inputs scrambled after accept
    op = 8'd5;
    data = 32'h281E140A;
    vld[0] = 1'b1;
    check("A tx idle before accept", 64'(txl[0]), 1);
    step();
    vld[0] = 1'b0;
    op = 8'($urandom);
    data = $urandom;
    verify("A", 0, 8'd5, 32'h281E140A, n);
    check("A 430-clk latency", n, NB == 7 ? 30101 : 25801);
    // inter-byte gap of 860 cycles
    o = 8'($urandom);
    d = $urandom;
    op = o;
    data = d;
    vld[2] = 1'b1;
    step();
    vld[2] = 1'b0;
    verify("gap", 2, o, d, n);
    // valid held high across two packets; second packet offered while busy
    op = 8'd0;
    data = 32'h04030201;
    vld[1] = 1'b1;
    step();
    op = 8'd1;
    data = 32'h281E140A;
    verify("b2b1", 1, 8'd0, 32'h04030201, n);
    check("b2b idle cycle tx", 64'(txl[1]), 1);
    step();
    vld[1] = 1'b0;
    verify("b2b2", 1, 8'd1, 32'h281E140A, n);
    // reset at byte 3 bit 4
    o = 8'($urandom);
    d = $urandom;
    op = o;
    data = d;
    vld[1] = 1'b1;
    step();
    vld[1] = 1'b0;
    at = 1 + 30 * 8 + 5 * 8 + 3;
    repeat (at - 1) step();
    check("mid tx byte3 bit4", 64'(txl[1]), 64'(d[12]));
    nRst = 1'b0;
    step();
    nRst = 1'b1;
    check("abort tx", 64'(txl[1]), 1);
    check("abort ready", 64'(rdy[1]), 1);
    check("abort busy", 64'(bsy[1]), 0);
    step();
    check("abort no stop tail", 64'(txl[1]), 1);
    o = 8'($urandom);
    d = $urandom;
    op = o;
    data = d;
    vld[1] = 1'b1;
    step();
    vld[1] = 1'b0;
    verify("after abort", 1, o, d, n);
    // reset wins over a simultaneous accept
    vld[1] = 1'b1;
    nRst = 1'b0;
    step();
    check("prio ready", 64'(rdy[1]), 1);
    check("prio tx", 64'(txl[1]), 1);
    nRst = 1'b1;
    o = 8'($urandom);
    d = $urandom;
    op = o;
    data = d;
    step();
    vld[1] = 1'b0;
    verify("prio pkt", 1, o, d, n);
    // random packets with inputs disturbed mid-packet
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 5)) step();
      o = 8'($urandom);
      d = $urandom;
      op = o;
      data = d;
      vld[1] = 1'b1;
      step();
      vld[1] = 1'b0;
      op = 8'($urandom);
      data = $urandom;
      verify($sformatf("rnd%0d", r), 1, o, d, n);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
